// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction-side and data-side requesters.
// One access at a time, held for LATENCY cycles, round-robin on simultaneous requests.
module mem_arbiter #(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic [WORD_SIZE-1:0] i_wdata,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,

  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,

  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,

  output logic                 busy
);

  localparam int unsigned CntW = $clog2(LATENCY + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            last_grant_q;  // 0 = I, 1 = D
  logic            we_q;

  logic i_elig, d_elig, grant_d, grant_we;

  // A side whose ready pulse is high has just been served and must re-request.
  assign i_elig   = i_req & ~i_ready;
  assign d_elig   = d_req & ~d_ready;
  assign grant_d  = d_elig & (~i_elig | ~last_grant_q);
  assign grant_we = grant_d ? d_we : i_we;
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      m_readM      <= 1'b0;
      m_writeM     <= 1'b0;
      m_address    <= '0;
      m_wdata      <= '0;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_elig | d_elig) begin
            state_q      <= grant_d ? StDBusy : StIBusy;
            last_grant_q <= grant_d;
            cnt_q        <= '0;
            we_q         <= grant_we;
            m_readM      <= ~grant_we;
            m_writeM     <= grant_we;
            m_address    <= grant_d ? d_addr : i_addr;
            m_wdata      <= grant_d ? d_wdata : i_wdata;
          end
        end
        StIBusy, StDBusy: begin
          if (cnt_q == CntLast) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            m_readM  <= 1'b0;
            m_writeM <= 1'b0;
            if (state_q == StIBusy) begin
              i_ready <= 1'b1;
              if (!we_q) i_rdata <= m_rdata;
            end else begin
              d_ready <= 1'b1;
              if (!we_q) d_rdata <= m_rdata;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector tables, hand-written corner sequences and
// randomized traffic checked against a cycle-timeline reference model.
module tb_mem_arbiter;

  localparam int unsigned L    = 2;
  localparam int          NCYC = 400;
  localparam int          NARR = 512;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_req, i_we, d_req, d_we;
  logic [15:0] i_addr, i_wdata, d_addr, d_wdata, m_rdata;
  logic        rd_force;
  logic [15:0] rd_val;

  logic [15:0] i_rdata, d_rdata, m_address, m_wdata;
  logic        i_ready, d_ready, m_readM, m_writeM, busy;
  logic [15:0] o1_i_rdata, o1_d_rdata, o1_m_address, o1_m_wdata;
  logic        o1_i_ready, o1_d_ready, o1_m_readM, o1_m_writeM, o1_busy;
  logic [15:0] o3_i_rdata, o3_d_rdata, o3_m_address, o3_m_wdata;
  logic        o3_i_ready, o3_d_ready, o3_m_readM, o3_m_writeM, o3_busy;

  always_comb m_rdata = rd_force ? rd_val : (m_address ^ 16'h5A3C);

  mem_arbiter #(.LATENCY(L), .WORD_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  mem_arbiter #(.LATENCY(1), .WORD_SIZE(16)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(o1_i_rdata), .i_ready(o1_i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(o1_d_rdata), .d_ready(o1_d_ready),
    .m_readM(o1_m_readM), .m_writeM(o1_m_writeM), .m_address(o1_m_address),
    .m_wdata(o1_m_wdata), .m_rdata(m_rdata), .busy(o1_busy)
  );

  mem_arbiter #(.LATENCY(3), .WORD_SIZE(16)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(o3_i_rdata), .i_ready(o3_i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(o3_d_rdata), .d_ready(o3_d_ready),
    .m_readM(o3_m_readM), .m_writeM(o3_m_writeM), .m_address(o3_m_address),
    .m_wdata(o3_m_wdata), .m_rdata(m_rdata), .busy(o3_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Packed view: {readM, writeM, busy, i_ready, d_ready, address, wdata, i_rdata, d_rdata}
  function automatic logic [68:0] pk(input logic rd, input logic wr, input logic bz,
                                     input logic ir, input logic dr, input logic [15:0] a,
                                     input logic [15:0] w, input logic [15:0] ird,
                                     input logic [15:0] drd);
    return {rd, wr, bz, ir, dr, a, w, ird, drd};
  endfunction

  function automatic logic [68:0] act_pk();
    return {m_readM, m_writeM, busy, i_ready, d_ready, m_address, m_wdata, i_rdata, d_rdata};
  endfunction

  typedef struct {
    logic        ireq, iwe;
    logic [15:0] iaddr;
    logic        dreq, dwe;
    logic [15:0] daddr, dwd;
    logic [68:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic ireq, input logic iwe, input logic [15:0] iaddr,
                              input logic dreq, input logic dwe, input logic [15:0] daddr,
                              input logic [15:0] dwd, input logic [68:0] exp);
    vec_t v;
    v.ireq = ireq; v.iwe = iwe; v.iaddr = iaddr;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.exp = exp;
    return v;
  endfunction

  task automatic clear_inputs();
    i_req = 0; i_we = 0; i_addr = 0; i_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
  endtask

  // Leaves the bench at a falling edge with reset released: that cycle is cycle 0.
  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    rd_force = 0;
    rd_val = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic run_table(input string name, input vec_t tbl[$]);
    foreach (tbl[k]) begin
      i_req = tbl[k].ireq; i_we = tbl[k].iwe; i_addr = tbl[k].iaddr; i_wdata = 0;
      d_req = tbl[k].dreq; d_we = tbl[k].dwe; d_addr = tbl[k].daddr; d_wdata = tbl[k].dwd;
      chk($sformatf("%s_c%0d", name, k), act_pk(), tbl[k].exp);
      @(negedge clk);
    end
  endtask

  // Reference model timeline: expected outputs per cycle, scheduled at grant time.
  bit          e_rd[NARR], e_wr[NARR], e_ir[NARR], e_dr[NARR], e_iread[NARR], e_dread[NARR];
  bit   [15:0] e_addr[NARR], e_wd[NARR], e_ival[NARR], e_dval[NARR];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t1[$];
    vec_t t2[$];

    // Single I read, memory returns 0x6000
    t1.push_back(mk(1, 0, 16'h0023, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    t1.push_back(mk(1, 0, 16'h0023, 0, 0, 0, 0, pk(1, 0, 1, 0, 0, 16'h0023, 0, 0, 0)));
    t1.push_back(mk(1, 0, 16'h0023, 0, 0, 0, 0, pk(1, 0, 1, 0, 0, 16'h0023, 0, 0, 0)));
    t1.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, pk(0, 0, 0, 1, 0, 16'h0023, 0, 16'h6000, 0)));
    t1.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 16'h0023, 0, 16'h6000, 0)));

    // Simultaneous I read and D write: I first, D granted in I's ready cycle
    t2.push_back(mk(1, 0, 16'h0010, 1, 1, 16'h0020, 16'hBEEF, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    t2.push_back(mk(1, 0, 16'h0010, 1, 1, 16'h0020, 16'hBEEF,
                    pk(1, 0, 1, 0, 0, 16'h0010, 0, 0, 0)));
    t2.push_back(mk(1, 0, 16'h0010, 1, 1, 16'h0020, 16'hBEEF,
                    pk(1, 0, 1, 0, 0, 16'h0010, 0, 0, 0)));
    t2.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0020, 16'hBEEF,
                    pk(0, 0, 0, 1, 0, 16'h0010, 0, 16'h7777, 0)));
    t2.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0020, 16'hBEEF,
                    pk(0, 1, 1, 0, 0, 16'h0020, 16'hBEEF, 16'h7777, 0)));
    t2.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0020, 16'hBEEF,
                    pk(0, 1, 1, 0, 0, 16'h0020, 16'hBEEF, 16'h7777, 0)));
    t2.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,
                    pk(0, 0, 0, 0, 1, 16'h0020, 16'hBEEF, 16'h7777, 0)));
    t2.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,
                    pk(0, 0, 0, 0, 0, 16'h0020, 16'hBEEF, 16'h7777, 0)));

    do_reset();
    rd_force = 1; rd_val = 16'h6000;
    run_table("iread", t1);

    do_reset();
    rd_force = 1; rd_val = 16'h7777;
    run_table("tie", t2);

    // Both sides hold req: grants must alternate I,D,I,D,I,D
    begin
      logic [15:0] order[$];
      logic        prev_rd, prev_ir, prev_dr;
      int          viol;
      do_reset();
      i_req = 1; i_addr = 16'h0100; d_req = 1; d_addr = 16'h0200;
      prev_rd = 0; prev_ir = 0; prev_dr = 0; viol = 0;
      for (int k = 0; k < 6 * (L + 1) + 1; k++) begin
        if (m_readM && !prev_rd) order.push_back(m_address);
        if ((i_ready && prev_ir) || (d_ready && prev_dr) || (i_ready && d_ready)) viol++;
        if (k > 0 && !busy && !(i_ready || d_ready)) viol++;
        prev_rd = m_readM; prev_ir = i_ready; prev_dr = d_ready;
        @(negedge clk);
      end
      chk("alt_count", order.size(), 6);
      for (int j = 0; j < 6 && j < order.size(); j++)
        chk($sformatf("alt_grant%0d", j), order[j], (j % 2 == 0) ? 16'h0100 : 16'h0200);
      chk("alt_pulse_busy", viol, 0);
    end

    // D read held through its ready cycle: new access only on the following cycle
    do_reset();
    rd_force = 1; rd_val = 16'h1234;
    d_req = 1; d_addr = 16'h0040;
    repeat (3) @(negedge clk);
    chk("dhold_ready", {d_ready, d_rdata, m_readM, busy}, {1'b1, 16'h1234, 1'b0, 1'b0});
    @(negedge clk);
    chk("dhold_gap", {m_readM, busy, d_ready}, 3'b000);
    @(negedge clk);
    chk("dhold_new", {m_readM, busy, m_address}, {1'b1, 1'b1, 16'h0040});
    d_req = 0;
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of a read
    begin
      int pulses;
      do_reset();
      i_req = 1; i_addr = 16'h0033;
      repeat (2) @(negedge clk);
      chk("abort_pre", {m_readM, busy}, 2'b11);
      #2 reset_n = 0;
      #1 chk("abort_now", {m_readM, m_writeM, busy}, 3'b000);
      i_req = 0;
      @(negedge clk);
      reset_n = 1;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
        if (i_ready || d_ready) pulses++;
        @(negedge clk);
      end
      chk("abort_no_ready", pulses, 0);
      i_req = 1; i_addr = 16'h0111; d_req = 1; d_addr = 16'h0222;
      @(negedge clk);
      chk("abort_tie_i", {m_readM, m_address}, {1'b1, 16'h0111});
      clear_inputs();
      repeat (8) @(negedge clk);
    end

    // LATENCY=1 and LATENCY=3 builds: strobe width and request-to-ready latency
    begin
      int n1, n3, r1, r3;
      do_reset();
      rd_force = 1; rd_val = 16'hCAFE;
      i_req = 1; i_addr = 16'h0055;
      n1 = 0; n3 = 0; r1 = -1; r3 = -1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (r1 < 0) begin
          if (o1_m_readM) n1++;
          if (o1_i_ready) r1 = k;
        end
        if (r3 < 0) begin
          if (o3_m_readM) n3++;
          if (o3_i_ready) r3 = k;
        end
      end
      i_req = 0;
      repeat (8) @(negedge clk);
      chk("lat1_strobe", n1, 1);
      chk("lat1_ready", r1, 2);
      chk("lat3_strobe", n3, 3);
      chk("lat3_ready", r3, 4);
      chk("lat1_idle", {o1_m_readM, o1_m_writeM, o1_busy, o1_i_ready, o1_d_ready, o1_m_address,
                        o1_m_wdata, o1_i_rdata, o1_d_rdata},
          pk(0, 0, 0, 0, 0, 16'h0055, 0, 16'hCAFE, 0));
      chk("lat3_idle", {o3_m_readM, o3_m_writeM, o3_busy, o3_i_ready, o3_d_ready, o3_m_address,
                        o3_m_wdata, o3_i_rdata, o3_d_rdata},
          pk(0, 0, 0, 0, 0, 16'h0055, 0, 16'hCAFE, 0));
    end

    // Randomized traffic against the timeline model
    begin
      bit          ip, dp, iwe, dwe, last, ie, de, g, we;
      bit   [15:0] ia, iw, da, dw, ma, mw, mi, md, a;
      int          free_at;
      do_reset();
      ip = 0; dp = 0; iwe = 0; dwe = 0; ia = 0; iw = 0; da = 0; dw = 0;
      ma = 0; mw = 0; mi = 0; md = 0; last = 1; free_at = 0;
      for (int c = 0; c < NCYC; c++) begin
        if (e_rd[c] || e_wr[c]) begin ma = e_addr[c]; mw = e_wd[c]; end
        if (e_ir[c] && e_iread[c]) mi = e_ival[c];
        if (e_dr[c] && e_dread[c]) md = e_dval[c];
        chk($sformatf("rand_c%0d", c), act_pk(),
            pk(e_rd[c], e_wr[c], e_rd[c] | e_wr[c], e_ir[c], e_dr[c], ma, mw, mi, md));

        if (e_ir[c]) ip = 0;
        if (!ip && $urandom_range(0, 2) != 0) begin
          ip = 1; iwe = 1'($urandom); ia = 16'($urandom); iw = 16'($urandom);
        end
        if (e_dr[c]) dp = 0;
        if (!dp && $urandom_range(0, 2) != 0) begin
          dp = 1; dwe = 1'($urandom); da = 16'($urandom); dw = 16'($urandom);
        end
        i_req = ip;
        i_we = ip ? iwe : 1'($urandom);
        i_addr = ip ? ia : 16'($urandom);
        i_wdata = ip ? iw : 16'($urandom);
        d_req = dp;
        d_we = dp ? dwe : 1'($urandom);
        d_addr = dp ? da : 16'($urandom);
        d_wdata = dp ? dw : 16'($urandom);

        if (c >= free_at) begin
          ie = ip && !e_ir[c];
          de = dp && !e_dr[c];
          if (ie || de) begin
            g = (ie && de) ? !last : de;
            last = g;
            we = g ? dwe : iwe;
            a = g ? da : ia;
            for (int k = 1; k <= int'(L); k++) begin
              e_rd[c + k] = !we; e_wr[c + k] = we;
              e_addr[c + k] = a; e_wd[c + k] = g ? dw : iw;
            end
            if (g) begin
              e_dr[c + L + 1] = 1; e_dread[c + L + 1] = !we; e_dval[c + L + 1] = a ^ 16'h5A3C;
            end else begin
              e_ir[c + L + 1] = 1; e_iread[c + L + 1] = !we; e_ival[c + L + 1] = a ^ 16'h5A3C;
            end
            free_at = c + int'(L) + 1;
          end
        end
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
